// File: rtl/han_multi_temp_monitor.sv
`timescale 1ns/1ps
// han_multi_temp_monitor: multi-channel LOW/OK/HI temperature classifier with Avalon-MM CSRs, sticky W1C alarms, masked irq; optional status LED under HAN_TEMP_LED_EN.
// Latency: sample -> CHn/state/fresh/ALARM on the accepting edge; irq one edge after ALARM; readdata one cycle after read.
// Backpressure: none; samples and bus accesses are always accepted, samples to channels >= NUM_CH are dropped.
module han_multi_temp_monitor #(
    parameter int NUM_CH    = 4,
    parameter int TEMP_W    = 8,
    parameter int HI_INIT   = 37,
    parameter int LO_INIT   = 32,
    parameter int HYST      = 2,
    parameter int FLASH_DIV = 5000000
) (
    input  logic              clk_50Mhz,
    input  logic              reset,
    input  logic [4:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              sample_valid,
    input  logic [3:0]        sample_ch,
    input  logic [TEMP_W-1:0] sample_temp,
    output logic [NUM_CH-1:0] temp_hi,
    output logic [NUM_CH-1:0] temp_ok,
    output logic [NUM_CH-1:0] temp_low,
    output logic              irq
`ifdef HAN_TEMP_LED_EN
   ,output logic              temp_led
`endif
);

    // Threshold comparisons carry one spare bit so the hysteresis subtraction can saturate cleanly.
    localparam int CW = TEMP_W + 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_OK   = 2'd2,
        ST_HI   = 2'd3
    } state_t;

    state_t             st_q   [NUM_CH];
    state_t             st_d   [NUM_CH];
    logic [15:0]        data_q [NUM_CH];
    logic [15:0]        data_d [NUM_CH];
    logic [NUM_CH-1:0]  fresh_q, fresh_d;
    logic [NUM_CH-1:0]  alarm_q, alarm_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [15:0]        thr_hi_q, thr_hi_d;
    logic [15:0]        thr_lo_q, thr_lo_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q;

    logic [NUM_CH-1:0]  smp_hit;
    logic [NUM_CH-1:0]  rd_ch;
    logic [NUM_CH-1:0]  hi_entry;
    logic               wr_thresh, wr_alarm, wr_mask;
    logic [CW-1:0]      t_ext, h_ext, l_ext, h_m, l_m, hyst_c;

    // Next-state rules for one channel given the current state and a new sample.
    function automatic state_t classify(input state_t cur, input logic [CW-1:0] t,
                                        input logic [CW-1:0] h, input logic [CW-1:0] l,
                                        input logic [CW-1:0] hm, input logic [CW-1:0] lm);
        state_t nxt;
        nxt = cur;
        case (cur)
            ST_INIT: nxt = (t > h) ? ST_HI : ((t < l) ? ST_LOW : ST_OK);
            ST_LOW:  nxt = (t > h) ? ST_HI : ((t >= l) ? ST_OK : ST_LOW);
            ST_OK:   nxt = (t > h) ? ST_HI : ((t < lm) ? ST_LOW : ST_OK);
            ST_HI:   nxt = (t < lm) ? ST_LOW : ((t <= hm) ? ST_OK : ST_HI);
            default: nxt = ST_INIT;
        endcase
        return nxt;
    endfunction

    // Address/strobe decode and hysteresis-adjusted thresholds (saturating at zero).
    always_comb begin
        wr_thresh = write && (address == 5'(NUM_CH));
        wr_alarm  = write && (address == 5'(NUM_CH + 1));
        wr_mask   = write && (address == 5'(NUM_CH + 2));
        for (int i = 0; i < NUM_CH; i++) begin
            smp_hit[i] = sample_valid && (sample_ch == 4'(i));
            rd_ch[i]   = read && (address == 5'(i));
        end
        hyst_c = CW'(HYST);
        t_ext  = {1'b0, sample_temp};
        h_ext  = {1'b0, thr_hi_q[TEMP_W-1:0]};
        l_ext  = {1'b0, thr_lo_q[TEMP_W-1:0]};
        h_m    = (h_ext >= hyst_c) ? (h_ext - hyst_c) : '0;
        l_m    = (l_ext >= hyst_c) ? (l_ext - hyst_c) : '0;
    end

    // Register next-state: channel data/state, fresh, alarms (set beats W1C), CSRs and read mux.
    always_comb begin
        hi_entry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]   = st_q[i];
            data_d[i] = data_q[i];
            if (smp_hit[i]) begin
                st_d[i]   = classify(st_q[i], t_ext, h_ext, l_ext, h_m, l_m);
                data_d[i] = 16'(sample_temp);
                if (st_d[i] == ST_HI && st_q[i] != ST_HI) begin
                    hi_entry[i] = 1'b1;
                end
            end
        end
        // A sample landing on the same edge as a read keeps fresh set.
        fresh_d = (fresh_q & ~rd_ch) | smp_hit;
        alarm_d = (alarm_q & ~(wr_alarm ? writedata[NUM_CH-1:0] : '0)) | hi_entry;
        mask_d  = wr_mask ? writedata[NUM_CH-1:0] : mask_q;

        thr_hi_d = thr_hi_q;
        thr_lo_d = thr_lo_q;
        if (wr_thresh && (writedata[31:16] < writedata[15:0])) begin
            thr_hi_d = writedata[15:0];
            thr_lo_d = writedata[31:16];
        end

        readdata_d = readdata_q;
        if (read) begin
            readdata_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 5'(i)) begin
                    readdata_d = {fresh_q[i], 13'b0, st_q[i], data_q[i]};
                end
            end
            if (address == 5'(NUM_CH))     readdata_d = {thr_lo_q, thr_hi_q};
            if (address == 5'(NUM_CH + 1)) readdata_d = 32'(alarm_q);
            if (address == 5'(NUM_CH + 2)) readdata_d = 32'(mask_q);
        end
    end

    // State registers with synchronous reset; irq is a registered view of masked alarms.
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= ST_INIT;
                data_q[i] <= '0;
            end
            fresh_q    <= '0;
            alarm_q    <= '0;
            mask_q     <= '0;
            thr_hi_q   <= 16'(HI_INIT);
            thr_lo_q   <= 16'(LO_INIT);
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= st_d[i];
                data_q[i] <= data_d[i];
            end
            fresh_q    <= fresh_d;
            alarm_q    <= alarm_d;
            mask_q     <= mask_d;
            thr_hi_q   <= thr_hi_d;
            thr_lo_q   <= thr_lo_d;
            readdata_q <= readdata_d;
            irq_q      <= |(alarm_q & mask_q);
        end
    end

    // One-hot state decode; INIT drives all three flags low.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            temp_hi[i]  = (st_q[i] == ST_HI);
            temp_ok[i]  = (st_q[i] == ST_OK);
            temp_low[i] = (st_q[i] == ST_LOW);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

`ifdef HAN_TEMP_LED_EN
    localparam int CNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             led_q, led_d;
    logic             flash_tick;

    // Flash divider wraps at FLASH_DIV-1; on each tick HI blinks, LOW lights solid, otherwise off.
    always_comb begin
        flash_tick  = (flash_cnt_q == CNT_W'(FLASH_DIV - 1));
        flash_cnt_d = flash_tick ? '0 : flash_cnt_q + 1'b1;
        led_d       = led_q;
        if (flash_tick) begin
            if (|temp_hi)       led_d = ~led_q;
            else if (|temp_low) led_d = 1'b1;
            else                led_d = 1'b0;
        end
    end

    // LED and divider registers.
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            flash_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            led_q       <= led_d;
        end
    end

    assign temp_led = led_q;
`endif

endmodule

// File: tb/tb_han_multi_temp_monitor.sv
`timescale 1ns/1ps
// Testbench for han_multi_temp_monitor: table-driven channel classification plus hand-written
// sequences for irq timing, W1C/set collisions, read/sample collisions, threshold writes and reset.
module tb_han_multi_temp_monitor;

    localparam int NUM_CH = 4;
    localparam int TEMP_W = 8;
    localparam logic [4:0] A_THR   = 5'(NUM_CH);
    localparam logic [4:0] A_ALARM = 5'(NUM_CH + 1);
    localparam logic [4:0] A_MASK  = 5'(NUM_CH + 2);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [4:0]        address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              sample_valid = 1'b0;
    logic [3:0]        sample_ch = '0;
    logic [TEMP_W-1:0] sample_temp = '0;
    logic [NUM_CH-1:0] temp_hi, temp_ok, temp_low;
    logic              irq;
`ifdef HAN_TEMP_LED_EN
    logic              temp_led;
`endif

    han_multi_temp_monitor #(
        .NUM_CH(NUM_CH), .TEMP_W(TEMP_W), .HI_INIT(37), .LO_INIT(32), .HYST(2), .FLASH_DIV(4)
    ) dut (
        .clk_50Mhz    (clk),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_temp  (sample_temp),
        .temp_hi      (temp_hi),
        .temp_ok      (temp_ok),
        .temp_low     (temp_low),
        .irq          (irq)
`ifdef HAN_TEMP_LED_EN
       ,.temp_led     (temp_led)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb_q[$];
    logic    rd_inflight = 1'b0;

    typedef struct {
        logic [TEMP_W-1:0] t;
        logic [1:0]        st;
        logic [NUM_CH-1:0] alarm;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: readdata is compared one cycle after each read strobe.
    always @(posedge clk) rd_inflight <= read;

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_inflight) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no read", readdata);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("rd_addr%0d", e.addr), readdata, e.exp);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                         input logic sv, input logic [3:0] ch, input logic [TEMP_W-1:0] t);
        @(negedge clk);
        read = rd; write = wr; address = addr; writedata = wd;
        sample_valid = sv; sample_ch = ch; sample_temp = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, '0);
    endtask

    task automatic bus_rd(input logic [4:0] addr, input logic [31:0] exp);
        rd_exp_t e;
        drive(1'b1, 1'b0, addr, 32'd0, 1'b0, 4'd0, '0);
        e.addr = addr; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] wd);
        drive(1'b0, 1'b1, addr, wd, 1'b0, 4'd0, '0);
    endtask

    task automatic smp(input logic [3:0] ch, input logic [TEMP_W-1:0] t);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ch, t);
    endtask

    task automatic check_st(input string tag, input logic [NUM_CH-1:0] hi, input logic [NUM_CH-1:0] ok,
                            input logic [NUM_CH-1:0] lo);
        check({tag, "_hi"},  32'(temp_hi),  32'(hi));
        check({tag, "_ok"},  32'(temp_ok),  32'(ok));
        check({tag, "_low"}, 32'(temp_low), 32'(lo));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_exp_t e;
        logic [NUM_CH-1:0] ehi, eok, elo;

        // ch1 sequence from INIT with H=37, L=32, HYST=2 (states: 1 LOW, 2 OK, 3 HI)
        tbl[0] = '{8'd30, 2'd1, 4'b0000};
        tbl[1] = '{8'd33, 2'd2, 4'b0000};
        tbl[2] = '{8'd31, 2'd2, 4'b0000};
        tbl[3] = '{8'd29, 2'd1, 4'b0000};
        tbl[4] = '{8'd38, 2'd3, 4'b0010};
        tbl[5] = '{8'd36, 2'd3, 4'b0010};
        tbl[6] = '{8'd35, 2'd2, 4'b0010};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check_st("rst", '0, '0, '0);
        bus_rd(A_THR, 32'h0020_0025);
        bus_rd(5'd0, 32'd0);
        bus_rd(A_MASK, 32'd0);

        // Table-driven classification of ch1
        for (int i = 0; i < 7; i++) begin
            smp(4'd1, tbl[i].t);
            bus_rd(5'd1, {1'b1, 13'b0, tbl[i].st, 16'(tbl[i].t)});
            ehi = (tbl[i].st == 2'd3) ? 4'b0010 : 4'b0000;
            eok = (tbl[i].st == 2'd2) ? 4'b0010 : 4'b0000;
            elo = (tbl[i].st == 2'd1) ? 4'b0010 : 4'b0000;
            check_st($sformatf("vec%0d", i), ehi, eok, elo);
            bus_rd(A_ALARM, 32'(tbl[i].alarm));
        end

        // irq timing: clear ALARM, unmask bit 1, drive ch1 into HI
        bus_wr(A_ALARM, 32'h2);
        bus_rd(A_ALARM, 32'h0);
        bus_wr(A_MASK, 32'h2);
        idle();
        idle();
        check("irq_idle", 32'(irq), 32'd0);
        smp(4'd1, 8'd40);
        idle();
        check("irq_edge_k", 32'(irq), 32'd0);
        check("hi_after_40", 32'(temp_hi), 32'h2);
        idle();
        check("irq_edge_k1", 32'(irq), 32'd1);

        // W1C with a sample that stays HI: no new entry, bit clears
        drive(1'b0, 1'b1, A_ALARM, 32'h2, 1'b1, 4'd1, 8'd41);
        bus_rd(A_ALARM, 32'h0);
        // Leave HI, then W1C together with a fresh HI entry: set wins
        smp(4'd1, 8'd20);
        drive(1'b0, 1'b1, A_ALARM, 32'h2, 1'b1, 4'd1, 8'd41);
        bus_rd(A_ALARM, 32'h2);
        idle();
        check("irq_set_wins", 32'(irq), 32'd1);
        check("hi_after_41", 32'(temp_hi), 32'h2);

        // Read of CH2 colliding with a ch2 sample: old contents returned, fresh survives
        drive(1'b1, 1'b0, 5'd2, 32'd0, 1'b1, 4'd2, 8'h21);
        e.addr = 5'd2; e.exp = 32'h0000_0000;
        sb_q.push_back(e);
        bus_rd(5'd2, 32'h8002_0021);
        bus_rd(5'd2, 32'h0002_0021);

        // Threshold writes: LO > HI and LO == HI ignored, valid write accepted
        bus_wr(A_THR, 32'h0028_001E);
        bus_rd(A_THR, 32'h0020_0025);
        bus_wr(A_THR, 32'h0025_0025);
        bus_rd(A_THR, 32'h0020_0025);
        bus_wr(A_THR, 32'h0014_0032);
        bus_rd(A_THR, 32'h0014_0032);
        // New thresholds (H=50, L=20) apply to the next sample: 45 <= 48 takes ch1 HI -> OK
        smp(4'd1, 8'd45);
        bus_rd(5'd1, 32'h8002_002D);

        // Out-of-range channel and writes to RO/unmapped addresses change nothing
        smp(4'(NUM_CH), 8'd50);
        bus_wr(5'd0, 32'hFFFF_FFFF);
        bus_wr(5'd31, 32'hFFFF_FFFF);
        idle();
        check_st("drop", 4'b0000, 4'b0110, 4'b0000);
        bus_rd(5'd0, 32'd0);
        bus_rd(5'd3, 32'd0);
        bus_rd(A_ALARM, 32'h2);
        bus_rd(A_MASK, 32'h2);
        bus_rd(5'd31, 32'd0);

        // Reset with a read in flight: readdata 0 and every register back to reset value
        drive(1'b1, 1'b0, A_THR, 32'd0, 1'b0, 4'd0, '0);
        reset = 1'b1;
        e.addr = A_THR; e.exp = 32'd0;
        sb_q.push_back(e);
        idle();
        reset = 1'b0;
        check_st("rst2", '0, '0, '0);
        check("rst2_irq", 32'(irq), 32'd0);
        bus_rd(A_THR, 32'h0020_0025);
        bus_rd(A_ALARM, 32'd0);
        bus_rd(A_MASK, 32'd0);
        bus_rd(5'd1, 32'd0);

`ifdef HAN_TEMP_LED_EN
        begin
            logic prev;
            bit   seen;
            smp(4'd0, 8'd40);
            idle();
            // Find a toggle (bounded), then confirm the 4-cycle period twice
            prev = temp_led;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                idle();
                if (temp_led !== prev) seen = 1'b1;
            end
            check("led_first_toggle", 32'(seen), 32'd1);
            for (int r = 0; r < 2; r++) begin
                prev = temp_led;
                for (int c = 0; c < 3; c++) begin
                    idle();
                    check("led_hold", 32'(temp_led), 32'(prev));
                end
                idle();
                check("led_toggle", 32'(temp_led), 32'(~prev));
            end
            smp(4'd0, 8'd34);
            repeat (6) idle();
            check("led_ok", 32'(temp_led), 32'd0);
            smp(4'd0, 8'd10);
            repeat (6) idle();
            check("led_low", 32'(temp_led), 32'd1);
        end
`endif

        repeat (3) idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
